// File: rtl/dcm_prog_ctrl.sv
// Run-time M/D reprogramming sequencer for a clock synthesizer's serial program
// port: validate, shift load-D / load-M / GO, wait for done and lock, retry on lock loss.
module dcm_prog_ctrl #(
  parameter int GAP_CYCLES   = 2,
  parameter int DONE_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RST_CYCLES   = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [5:0] div_val,
  input  logic [5:0] mul_val,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       prog_en,
  output logic       prog_data,
  input  logic       prog_done,
  input  logic       locked,
  output logic       dcm_rst
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD_D    = 4'd1;
  localparam logic [3:0] S_GAP_D     = 4'd2;
  localparam logic [3:0] S_LOAD_M    = 4'd3;
  localparam logic [3:0] S_GAP_M     = 4'd4;
  localparam logic [3:0] S_GO        = 4'd5;
  localparam logic [3:0] S_WAIT_DONE = 4'd6;
  localparam logic [3:0] S_WAIT_LOCK = 4'd7;
  localparam logic [3:0] S_RST       = 4'd8;

  // One shared counter covers frame bits, gaps, reset hold and both timeouts.
  localparam int T_A = (DONE_TIMEOUT > LOCK_TIMEOUT) ? DONE_TIMEOUT : LOCK_TIMEOUT;
  localparam int T_B = (T_A > 16) ? T_A : 16;
  localparam int T_C = (T_B > RST_CYCLES) ? T_B : RST_CYCLES;
  localparam int T_D = (T_C > GAP_CYCLES) ? T_C : GAP_CYCLES;
  localparam int CW  = $clog2(T_D + 1);
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] FRAME_LAST = CW'(9);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DONE_LAST  = CW'(DONE_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic [7:0]    d_m1;
  logic [7:0]    m_m1;
  logic [9:0]    frame_d;
  logic [9:0]    frame_m;
  logic          vals_ok;

  // Frames go out LSB first: two header bits, then the 8-bit value minus one.
  assign frame_d = {d_m1, 2'b01};
  assign frame_m = {m_m1, 2'b11};
  assign vals_ok = (div_val >= 6'd1) && (div_val <= 6'd32) &&
                   (mul_val >= 6'd2) && (mul_val <= 6'd32);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      retry     <= '0;
      d_m1      <= '0;
      m_m1      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      prog_en   <= 1'b0;
      prog_data <= 1'b0;
      dcm_rst   <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      prog_en   <= 1'b0;
      prog_data <= 1'b0;
      dcm_rst   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            d_m1     <= {2'b00, div_val} - 8'd1;
            m_m1     <= {2'b00, mul_val} - 8'd1;
            err_code <= 2'd0;
            if (vals_ok) begin
              state <= S_LOAD_D;
              cnt   <= '0;
              retry <= '0;
              busy  <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd1;
            end
          end
        end
        S_LOAD_D: begin
          prog_en   <= 1'b1;
          prog_data <= frame_d[cnt[3:0]];
          if (cnt == FRAME_LAST) begin
            state <= S_GAP_D;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP_D: begin
          if (cnt == GAP_LAST) begin
            state <= S_LOAD_M;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOAD_M: begin
          prog_en   <= 1'b1;
          prog_data <= frame_m[cnt[3:0]];
          if (cnt == FRAME_LAST) begin
            state <= S_GAP_M;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP_M: begin
          if (cnt == GAP_LAST) begin
            state <= S_GO;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GO: begin
          prog_en <= 1'b1;
          state   <= S_WAIT_DONE;
          cnt     <= '0;
        end
        S_WAIT_DONE: begin
          if (prog_done) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == DONE_LAST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'd2;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          // Lock loss is retried by resetting the synthesizer and reprogramming the latched values.
          if (locked) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            retry <= '0;
          end else if (cnt == LOCK_LAST) begin
            cnt <= '0;
            if (retry < RETRY_MAX) begin
              state <= S_RST;
              retry <= retry + RW'(1);
            end else begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= 2'd3;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RST: begin
          dcm_rst <= 1'b1;
          if (cnt == RST_LAST) begin
            state <= S_LOAD_D;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Scoreboard bench for dcm_prog_ctrl: a synthesizer model answers GO commands and a
// monitor turns output activity into timestamped events checked against an expected queue.
`timescale 1ns/1ps
module tb_dcm_prog_ctrl;

  localparam int EV_FRAME = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_RST   = 3;

  typedef struct {
    int kind;
    int start;
    int len;
    int data;
  } ev_t;

  typedef struct {
    int div;
    int mul;
    int dframe;
    int mframe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [5:0] div_val = '0;
  logic [5:0] mul_val = '0;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       prog_en;
  logic       prog_data;
  logic       prog_done = 1'b0;
  logic       locked = 1'b0;
  logic       dcm_rst;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  ev_t exp_q[$];

  int done_delay = 10;
  int lock_delay = 20;
  int lock_on_go = 1;
  int go_cnt = 0;
  int go_cyc = -1;
  logic pe_prev = 1'b0;

  dcm_prog_ctrl #(
    .GAP_CYCLES  (2),
    .DONE_TIMEOUT(16),
    .LOCK_TIMEOUT(32),
    .RST_CYCLES  (8),
    .MAX_RETRY   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .div_val  (div_val),
    .mul_val  (mul_val),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .prog_en  (prog_en),
    .prog_data(prog_data),
    .prog_done(prog_done),
    .locked   (locked),
    .dcm_rst  (dcm_rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synthesizer model: a frame starting with data 0 is GO; answer with prog_done and, on the chosen GO, locked.
  always @(negedge clk) begin
    if (!rst_n) begin
      prog_done = 1'b0;
      locked    = 1'b0;
      go_cyc    = -1;
      go_cnt    = 0;
    end else begin
      if (req && !busy) begin
        go_cnt = 0;
        go_cyc = -1;
      end
      if (prog_en && !prog_data && !pe_prev) begin
        go_cnt = go_cnt + 1;
        go_cyc = cyc;
      end
      if (prog_en || dcm_rst) locked = 1'b0;
      prog_done = (go_cyc >= 0 && done_delay > 0 && cyc == go_cyc + done_delay);
      if (go_cyc >= 0 && done_delay > 0 && lock_on_go > 0 && go_cnt == lock_on_go &&
          cyc == go_cyc + done_delay + lock_delay)
        locked = 1'b1;
    end
    pe_prev = prog_en;
  end

  task automatic check_output(input ev_t got);
    ev_t want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_unexpected got kind=%0d start=%0d len=%0d data=%0h, want no event",
               got.kind, got.start, got.len, got.data);
    end else begin
      want = exp_q.pop_front();
      if (got.kind != want.kind || got.start != want.start ||
          got.len != want.len || got.data != want.data) begin
        errors++;
        $display("[TB] FAIL sb_event got kind=%0d start=%0d len=%0d data=%0h, want kind=%0d start=%0d len=%0d data=%0h",
                 got.kind, got.start, got.len, got.data,
                 want.kind, want.start, want.len, want.data);
      end
    end
  endtask

  // Monitor: program frames and dcm_rst runs are reported when they end, pulses when seen.
  int   f_start = 0, f_len = 0, f_data = 0, r_start = 0, r_len = 0;
  logic in_frame = 1'b0, in_rst = 1'b0;
  always @(negedge clk) begin
    ev_t ev;
    if (prog_en) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        f_start  = cyc;
        f_len    = 0;
        f_data   = 0;
      end
      if (f_len < 31) f_data = f_data | (int'(prog_data) << f_len);
      f_len++;
    end else if (in_frame) begin
      in_frame = 1'b0;
      ev = '{EV_FRAME, f_start, f_len, f_data};
      check_output(ev);
    end
    if (dcm_rst) begin
      if (!in_rst) begin
        in_rst  = 1'b1;
        r_start = cyc;
        r_len   = 0;
      end
      r_len++;
    end else if (in_rst) begin
      in_rst = 1'b0;
      ev = '{EV_RST, r_start, r_len, 0};
      check_output(ev);
    end
    if (done) begin
      ev = '{EV_DONE, cyc, 1, 0};
      check_output(ev);
    end
    if (err) begin
      ev = '{EV_ERR, cyc, 1, int'(err_code)};
      check_output(ev);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_signal(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input int d, input int m, output int k);
    div_val = 6'(d);
    mul_val = 6'(m);
    req     = 1'b1;
    k       = cyc + 1;
    tick();
    req     = 1'b0;
  endtask

  task automatic push_ev(input int kind, input int start, input int len, input int data);
    ev_t e;
    e = '{kind, start, len, data};
    exp_q.push_back(e);
  endtask

  task automatic push_attempt(input int b, input int dframe, input int mframe);
    push_ev(EV_FRAME, b + 1, 10, dframe);
    push_ev(EV_FRAME, b + 13, 10, mframe);
    push_ev(EV_FRAME, b + 25, 1, 0);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain got %0d events pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_signal({tag, "_busy"}, int'(busy), 0);
    check_signal({tag, "_done"}, int'(done), 0);
    check_signal({tag, "_err"}, int'(err), 0);
    check_signal({tag, "_err_code"}, int'(err_code), 0);
    check_signal({tag, "_prog_en"}, int'(prog_en), 0);
    check_signal({tag, "_prog_data"}, int'(prog_data), 0);
    check_signal({tag, "_dcm_rst"}, int'(dcm_rst), 0);
  endtask

  // Hand-computed frames: D = {D-1, 2'b01}, M = {M-1, 2'b11}, bit 0 sent first.
  vec_t good_vecs[3] = '{
    '{5, 8, 'h011, 'h01F},
    '{1, 2, 'h001, 'h007},
    '{32, 32, 'h07D, 'h07F}
  };
  int bad_vecs[4][2] = '{'{0, 8}, '{5, 1}, '{33, 8}, '{5, 33}};

  initial begin
    int k;
    int b;
    tick();
    check_all_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("[TB] normal programming with lock on first GO");
    done_delay = 10;
    lock_on_go = 1;
    foreach (good_vecs[i]) begin
      apply_stimulus(good_vecs[i].div, good_vecs[i].mul, k);
      check_signal("accept_busy", int'(busy), 1);
      push_attempt(k, good_vecs[i].dframe, good_vecs[i].mframe);
      push_ev(EV_DONE, k + 56, 1, 0);
      repeat (3) tick();
      req = 1'b1;
      tick();
      req = 1'b0;
      wait_drain("normal", 100);
      repeat (30) tick();
      check_signal("normal_busy_after", int'(busy), 0);
    end

    $display("[TB] invalid values");
    foreach (bad_vecs[i]) begin
      apply_stimulus(bad_vecs[i][0], bad_vecs[i][1], k);
      push_ev(EV_ERR, k, 1, 1);
      check_signal("invalid_busy", int'(busy), 0);
      repeat (4) tick();
      check_signal("invalid_code_hold", int'(err_code), 1);
      wait_drain("invalid", 10);
    end

    $display("[TB] program done timeout");
    done_delay = -1;
    apply_stimulus(3, 20, k);
    check_signal("timeout_code_cleared", int'(err_code), 0);
    push_attempt(k, 'h009, 'h04F);
    push_ev(EV_ERR, k + 41, 1, 2);
    wait_drain("done_timeout", 80);
    tick();
    check_signal("timeout_busy", int'(busy), 0);
    check_signal("timeout_prog_en", int'(prog_en), 0);
    repeat (10) tick();

    $display("[TB] lock never arrives, retries exhausted");
    done_delay = 10;
    lock_on_go = 0;
    apply_stimulus(7, 9, k);
    for (int a = 0; a < 3; a++) begin
      b = k + 76 * a;
      push_attempt(b, 'h019, 'h023);
      if (a < 2) push_ev(EV_RST, b + 69, 8, 0);
      else push_ev(EV_ERR, b + 68, 1, 3);
    end
    wait_drain("lock_fail", 300);
    tick();
    check_signal("lock_fail_code", int'(err_code), 3);
    repeat (10) tick();

    $display("[TB] lock on second retry, then retry count starts fresh");
    lock_on_go = 3;
    for (int r = 0; r < 2; r++) begin
      apply_stimulus(2, 16, k);
      for (int a = 0; a < 3; a++) begin
        b = k + 76 * a;
        push_attempt(b, 'h005, 'h03F);
        if (a < 2) push_ev(EV_RST, b + 69, 8, 0);
        else push_ev(EV_DONE, b + 56, 1, 0);
      end
      wait_drain("late_lock", 300);
      tick();
      check_signal("late_lock_busy", int'(busy), 0);
      repeat (10) tick();
    end

    $display("[TB] reset during LOAD_M with req toggled while busy");
    lock_on_go = 1;
    apply_stimulus(5, 10, k);
    push_ev(EV_FRAME, k + 1, 10, 'h011);
    push_ev(EV_FRAME, k + 13, 4, 'h007);
    repeat (4) tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check_signal("post_reset_busy", int'(busy), 0);
    wait_drain("reset_abort", 5);
    apply_stimulus(5, 10, k);
    push_attempt(k, 'h011, 'h027);
    push_ev(EV_DONE, k + 56, 1, 0);
    wait_drain("post_reset_req", 100);
    repeat (20) tick();
    check_signal("final_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
